projectile_engine: RTL and testbench
====================================

Name: projectile_engine

Overview:
- Parametrised multi-ball physics and pixel engine, successor to the single-ball mover in the thrower game.
- Simulates up to N_BALLS independent projectiles under gravity, one update per frame tick.
- Reports ground landings and target hits, and drives a registered per-pixel ball mask into the VGA colour mux.
- Sits between the launch/aim logic (velocity look-up) and the display stage; runs on the VGA pixel clock.

Parameters:
- N_BALLS, 4, number of ball channels (1..8).
- COORD_W, 10, screen coordinate width.
- VEL_W, 10, signed velocity width.
- BALL_SIZE, 8, ball square side in pixels.
- START_X, 40, launch x position.
- START_Y, 440, launch y position (top edge).
- GROUND_Y, 450, first ground row.
- SCREEN_W, 640, visible width.
- GRAVITY, 1, vy decrement per frame.
- TARGET_LO, 420, target x lower bound (exclusive).
- TARGET_HI, 540, target x upper bound (exclusive).
- HOLD_FRAMES, 60, frames a landed ball stays visible.

Ports:
- clk, in, 1: VGA pixel clock.
- rst, in, 1: asynchronous, active-low reset.
- frame_tick, in, 1: one-cycle pulse per frame.
- launch, in, 1: one-cycle launch request.
- launch_vx, in, VEL_W: signed horizontal velocity.
- launch_vy, in, VEL_W: signed vertical velocity, positive = up.
- x_count, in, COORD_W: current pixel x.
- y_count, in, COORD_W: current pixel y.
- ball_pix, out, 1: current pixel is covered by an active ball.
- ball_id, out, clog2(N_BALLS): lowest-index ball covering the pixel.
- busy_mask, out, N_BALLS: channel is not IDLE.
- launch_drop, out, 1: launch rejected because no channel was free.
- land_valid, out, 1: landing event strobe.
- land_id, out, clog2(N_BALLS): ball that landed.
- land_x, out, COORD_W: left edge of the landed ball.
- land_hit, out, 1: the landing was inside the target.
- score, out, 8: saturating count of target hits.

Behaviour:
- Reset (asynchronous, active-low):
  - all channels IDLE; all outputs 0; score 0; pending-event mask cleared.
- Per-channel FSM, states IDLE, FLIGHT, LANDED:
  - IDLE -> FLIGHT on allocation.
  - FLIGHT -> LANDED on ground contact.
  - FLIGHT -> IDLE when the ball leaves the screen.
  - LANDED -> IDLE after HOLD_FRAMES frame ticks.
- Launch:
  - Allocates the lowest-index IDLE channel and loads x=START_X, y=START_Y, vx, vy.
  - If no channel is IDLE, launch_drop pulses for 1 cycle and all state is unchanged.
  - If launch and frame_tick coincide, the new ball is not advanced that frame.
- Frame update, FLIGHT channels only, in the frame_tick cycle:
  - x' = x + vx
  - y' = y - vy (uses the old vy)
  - vy' = vy - GRAVITY
- Arithmetic width:
  - Positions are held signed at COORD_W+2 bits so that negative and overflowed positions are detectable.
  - Velocities are sign-extended before addition.
- Ground contact: y' + BALL_SIZE >= GROUND_Y.
  - Clamp y to GROUND_Y - BALL_SIZE.
  - State -> LANDED.
  - Set the channel's pending-event bit.
- Off-screen: x' < 0 or x' >= SCREEN_W.
  - State -> IDLE; no landing event.
  - If this occurs in the same frame as ground contact, off-screen wins.
- A ball going above y=0 stays in FLIGHT; it is simply not drawn.
- Event serializer:
  - Emits one pending landing per cycle, lowest index first.
  - land_valid is high for 1 cycle per event.
  - land_hit = (x + BALL_SIZE/2 > TARGET_LO) && (x + BALL_SIZE/2 < TARGET_HI).
  - score increments on land_hit and saturates at 255.
  - Up to N_BALLS events in one frame drain within N_BALLS cycles, with no loss.
- Pixel path:
  - Coverage test: x <= x_count < x+BALL_SIZE and y <= y_count < y+BALL_SIZE, for FLIGHT or LANDED channels.
  - ball_pix and ball_id are registered, so latency is 1 clk.
  - ball_id holds 0 when ball_pix is 0.
- busy_mask is registered and is updated the cycle after the state change.

Optional Feature:
- Macro: PROJECTILE_BOUNCE_EN.
- Defined:
  - On ground contact with |vy| >= 4: y is clamped, vy' = (-vy) >>> 1 (arithmetic shift), the ball stays in FLIGHT, and no event is raised.
  - With |vy| < 4: transition to LANDED and raise the event as normal.
- Undefined: the ball lands on first contact; no bounce logic is synthesised.

Decomposition:
- Package projectile_pkg holds:
  - the state enum (IDLE/FLIGHT/LANDED);
  - the ball record typedef {state, x, y, vx, vy, hold_cnt};
  - the bounce threshold constant;
  - the ID width function (clog2 of N_BALLS).
- One sub-module, projectile_channel:
  - contains one ball's FSM, arithmetic and coverage compare;
  - is instantiated N_BALLS times via generate.
- The allocator, event serializer, score counter and pixel priority encoder stay in the top.

Test Plan:
- launch vx=5, vy=10, then 3 frame ticks -> x=55, y=413, vy=7.
- Launch with all 4 channels busy -> launch_drop=1 for 1 cycle; busy_mask stays 4'b1111.
- Ball with vx=0, vy=0 at START_Y=440, one frame tick:
  - y'=440 gives 448 < 450, so no contact on tick 1;
  - with vy=-3 the ball lands: land_valid, land_x=40, land_hit=0.
- Two balls landing in the same frame at x=470 and x=100 -> two consecutive land_valid cycles (id0 then id1), hit=1 then hit=0, score=1.
- vx=-50 from x=40 -> ball goes IDLE next tick; no land event.
- Pixel scan with a ball at (200,300), x_count=203, y_count=305 -> ball_pix=1 one cycle later; x_count=208 -> ball_pix=0.
- Assert rst mid-flight -> all outputs 0 immediately; score cleared.

Source files
------------

// File: rtl/projectile_pkg.sv
// ============================================================================
// Module      : projectile_pkg
// Description : Shared types and constants for the multi-ball projectile engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package projectile_pkg;

  localparam int c_coord_w       = 10;
  localparam int c_vel_w         = 10;
  localparam int c_hold_w        = 8;
  localparam int c_pos_w         = c_coord_w + 2;
  localparam int c_bounce_min_vy = 4;

  typedef logic signed [c_pos_w-1:0] pos_t;
  typedef logic signed [c_vel_w-1:0] vel_t;
  typedef logic [c_hold_w-1:0]       hold_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_LANDED = 2'd2
  } ball_state_e;

  typedef struct packed {
    ball_state_e state;
    pos_t        x;
    pos_t        y;
    vel_t        vx;
    vel_t        vy;
    hold_t       hold_cnt;
  } ball_t;

  // Index width for a ball channel; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/projectile_channel.sv
// ============================================================================
// Module      : projectile_channel
// Description : One ball: IDLE/FLIGHT/LANDED FSM, frame physics, pixel cover.
//               Optional bounce on ground contact under PROJECTILE_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module projectile_channel
  import projectile_pkg::*;
#(
  parameter int COORD_W     = c_coord_w,
  parameter int VEL_W       = c_vel_w,
  parameter int BALL_SIZE   = 8,
  parameter int START_X     = 40,
  parameter int START_Y     = 440,
  parameter int GROUND_Y    = 450,
  parameter int SCREEN_W    = 640,
  parameter int GRAVITY     = 1,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               alloc,
  input  logic [VEL_W-1:0]   launch_vx,
  input  logic [VEL_W-1:0]   launch_vy,
  input  logic [COORD_W-1:0] x_count,
  input  logic [COORD_W-1:0] y_count,
  output ball_state_e        ball_state,
  output pos_t               ball_x,
  output logic               covered,
  output logic               land_evt
);

  localparam pos_t  c_start_x   = pos_t'(START_X);
  localparam pos_t  c_start_y   = pos_t'(START_Y);
  localparam pos_t  c_ground_y  = pos_t'(GROUND_Y);
  localparam pos_t  c_screen_w  = pos_t'(SCREEN_W);
  localparam pos_t  c_ball_size = pos_t'(BALL_SIZE);
  localparam pos_t  c_rest_y    = pos_t'(GROUND_Y - BALL_SIZE);
  localparam vel_t  c_gravity   = vel_t'(GRAVITY);
  localparam hold_t c_hold_last = hold_t'(HOLD_FRAMES - 1);

  ball_t ball_q, ball_d;
  pos_t  nx, ny, px, py;
  vel_t  nvy;

`ifdef PROJECTILE_BOUNCE_EN
  localparam logic signed [c_vel_w:0] c_bounce_lim = (c_vel_w + 1)'(c_bounce_min_vy);

  logic signed [c_vel_w:0] vy_ext, vy_neg, vy_abs;

  // One extra bit so negating the most negative velocity cannot overflow.
  always_comb begin
    vy_ext = {ball_q.vy[c_vel_w-1], ball_q.vy};
    vy_neg = -vy_ext;
    vy_abs = vy_ext[c_vel_w] ? vy_neg : vy_ext;
  end
`endif

  always_comb begin
    ball_d   = ball_q;
    land_evt = 1'b0;
    nx       = ball_q.x + pos_t'(ball_q.vx);
    ny       = ball_q.y - pos_t'(ball_q.vy);
    nvy      = ball_q.vy - c_gravity;

    unique case (ball_q.state)
      ST_IDLE: begin
        if (alloc) begin
          ball_d.state    = ST_FLIGHT;
          ball_d.x        = c_start_x;
          ball_d.y        = c_start_y;
          ball_d.vx       = vel_t'(launch_vx);
          ball_d.vy       = vel_t'(launch_vy);
          ball_d.hold_cnt = '0;
        end
      end
      ST_FLIGHT: begin
        if (frame_tick) begin
          ball_d.x = nx;
          // Leaving the screen takes priority over touching the ground.
          if (nx[c_pos_w-1] || (nx >= c_screen_w)) begin
            ball_d.state = ST_IDLE;
          end else if ((ny + c_ball_size) >= c_ground_y) begin
            ball_d.y = c_rest_y;
`ifdef PROJECTILE_BOUNCE_EN
            if (vy_abs >= c_bounce_lim) begin
              ball_d.vy = vel_t'(vy_neg >>> 1);
            end else begin
              ball_d.state    = ST_LANDED;
              ball_d.vy       = nvy;
              ball_d.hold_cnt = '0;
              land_evt        = 1'b1;
            end
`else
            ball_d.state    = ST_LANDED;
            ball_d.vy       = nvy;
            ball_d.hold_cnt = '0;
            land_evt        = 1'b1;
`endif
          end else begin
            ball_d.y  = ny;
            ball_d.vy = nvy;
          end
        end
      end
      ST_LANDED: begin
        if (frame_tick) begin
          if (ball_q.hold_cnt == c_hold_last) begin
            ball_d.state    = ST_IDLE;
            ball_d.hold_cnt = '0;
          end else begin
            ball_d.hold_cnt = ball_q.hold_cnt + hold_t'(1);
          end
        end
      end
      default: ball_d.state = ST_IDLE;
    endcase
  end

  always_comb begin
    px      = pos_t'(x_count);
    py      = pos_t'(y_count);
    covered = (ball_q.state != ST_IDLE) &&
              (px >= ball_q.x) && (px < (ball_q.x + c_ball_size)) &&
              (py >= ball_q.y) && (py < (ball_q.y + c_ball_size));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ball_q <= '0;
    end else begin
      ball_q <= ball_d;
    end
  end

  assign ball_state = ball_q.state;
  assign ball_x     = ball_q.x;

endmodule

`default_nettype wire

// File: rtl/projectile_engine.sv
// ============================================================================
// Module      : projectile_engine
// Description : N-ball projectile engine: allocator, landing event serializer,
//               score counter and registered pixel mask. Macro: PROJECTILE_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module projectile_engine
  import projectile_pkg::*;
#(
  parameter int N_BALLS     = 4,
  parameter int COORD_W     = c_coord_w,
  parameter int VEL_W       = c_vel_w,
  parameter int BALL_SIZE   = 8,
  parameter int START_X     = 40,
  parameter int START_Y     = 440,
  parameter int GROUND_Y    = 450,
  parameter int SCREEN_W    = 640,
  parameter int GRAVITY     = 1,
  parameter int TARGET_LO   = 420,
  parameter int TARGET_HI   = 540,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           launch,
  input  logic [VEL_W-1:0]               launch_vx,
  input  logic [VEL_W-1:0]               launch_vy,
  input  logic [COORD_W-1:0]             x_count,
  input  logic [COORD_W-1:0]             y_count,
  output logic                           ball_pix,
  output logic [id_width(N_BALLS)-1:0]   ball_id,
  output logic [N_BALLS-1:0]             busy_mask,
  output logic                           launch_drop,
  output logic                           land_valid,
  output logic [id_width(N_BALLS)-1:0]   land_id,
  output logic [COORD_W-1:0]             land_x,
  output logic                           land_hit,
  output logic [7:0]                     score
);

  localparam int   c_id_w      = id_width(N_BALLS);
  localparam pos_t c_half      = pos_t'(BALL_SIZE / 2);
  localparam pos_t c_target_lo = pos_t'(TARGET_LO);
  localparam pos_t c_target_hi = pos_t'(TARGET_HI);

  ball_state_e        st [N_BALLS];
  pos_t               bx [N_BALLS];
  logic [N_BALLS-1:0] alloc, covered, land_evt;

  logic               ball_pix_q, ball_pix_d;
  logic [c_id_w-1:0]  ball_id_q, ball_id_d;
  logic [N_BALLS-1:0] busy_q, busy_d;
  logic               launch_drop_q, launch_drop_d;
  logic [N_BALLS-1:0] pend_q, pend_d;
  logic               land_valid_q, land_valid_d;
  logic [c_id_w-1:0]  land_id_q, land_id_d;
  logic [COORD_W-1:0] land_x_q, land_x_d;
  logic               land_hit_q, land_hit_d;
  logic [7:0]         score_q, score_d;

  for (genvar g = 0; g < N_BALLS; g++) begin : g_ch
    projectile_channel #(
      .COORD_W     (COORD_W),
      .VEL_W       (VEL_W),
      .BALL_SIZE   (BALL_SIZE),
      .START_X     (START_X),
      .START_Y     (START_Y),
      .GROUND_Y    (GROUND_Y),
      .SCREEN_W    (SCREEN_W),
      .GRAVITY     (GRAVITY),
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .alloc      (alloc[g]),
      .launch_vx  (launch_vx),
      .launch_vy  (launch_vy),
      .x_count    (x_count),
      .y_count    (y_count),
      .ball_state (st[g]),
      .ball_x     (bx[g]),
      .covered    (covered[g]),
      .land_evt   (land_evt[g])
    );
  end

  // Launch goes to the lowest-index idle channel, or is dropped.
  always_comb begin
    logic found;
    found         = 1'b0;
    alloc         = '0;
    launch_drop_d = 1'b0;
    busy_d        = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      busy_d[i] = (st[i] != ST_IDLE);
      if (!found && (st[i] == ST_IDLE)) begin
        found    = 1'b1;
        alloc[i] = launch;
      end
    end
    launch_drop_d = launch && !found;
  end

  // Descending scan so the lowest covering index wins.
  always_comb begin
    ball_pix_d = |covered;
    ball_id_d  = '0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (covered[i]) begin
        ball_id_d = c_id_w'(i);
      end
    end
  end

  always_comb begin
    logic               got;
    logic [N_BALLS-1:0] served;
    pos_t               center;
    got          = 1'b0;
    served       = '0;
    center       = '0;
    land_valid_d = 1'b0;
    land_id_d    = '0;
    land_x_d     = '0;
    land_hit_d   = 1'b0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (!got && pend_q[i]) begin
        got          = 1'b1;
        served[i]    = 1'b1;
        center       = bx[i] + c_half;
        land_valid_d = 1'b1;
        land_id_d    = c_id_w'(i);
        land_x_d     = bx[i][COORD_W-1:0];
        land_hit_d   = (center > c_target_lo) && (center < c_target_hi);
      end
    end
    pend_d  = (pend_q & ~served) | land_evt;
    score_d = score_q;
    if (land_valid_d && land_hit_d && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ball_pix_q    <= 1'b0;
      ball_id_q     <= '0;
      busy_q        <= '0;
      launch_drop_q <= 1'b0;
      pend_q        <= '0;
      land_valid_q  <= 1'b0;
      land_id_q     <= '0;
      land_x_q      <= '0;
      land_hit_q    <= 1'b0;
      score_q       <= '0;
    end else begin
      ball_pix_q    <= ball_pix_d;
      ball_id_q     <= ball_id_d;
      busy_q        <= busy_d;
      launch_drop_q <= launch_drop_d;
      pend_q        <= pend_d;
      land_valid_q  <= land_valid_d;
      land_id_q     <= land_id_d;
      land_x_q      <= land_x_d;
      land_hit_q    <= land_hit_d;
      score_q       <= score_d;
    end
  end

  assign ball_pix    = ball_pix_q;
  assign ball_id     = ball_id_q;
  assign busy_mask   = busy_q;
  assign launch_drop = launch_drop_q;
  assign land_valid  = land_valid_q;
  assign land_id     = land_id_q;
  assign land_x      = land_x_q;
  assign land_hit    = land_hit_q;
  assign score       = score_q;

endmodule

`default_nettype wire

// File: tb/tb_projectile_engine.sv
// ============================================================================
// Module      : tb_projectile_engine
// Description : Directed self-checking bench for projectile_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_projectile_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       launch;
  logic [9:0] launch_vx, launch_vy;
  logic [9:0] x_count, y_count;
  logic       ball_pix;
  logic [1:0] ball_id;
  logic [3:0] busy_mask;
  logic       launch_drop;
  logic       land_valid;
  logic [1:0] land_id;
  logic [9:0] land_x;
  logic       land_hit;
  logic [7:0] score;

  int tests_run    = 0;
  int tests_failed = 0;

  projectile_engine dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .launch      (launch),
    .launch_vx   (launch_vx),
    .launch_vy   (launch_vy),
    .x_count     (x_count),
    .y_count     (y_count),
    .ball_pix    (ball_pix),
    .ball_id     (ball_id),
    .busy_mask   (busy_mask),
    .launch_drop (launch_drop),
    .land_valid  (land_valid),
    .land_id     (land_id),
    .land_x      (land_x),
    .land_hit    (land_hit),
    .score       (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic do_launch(input int vx, input int vy);
    launch    = 1'b1;
    launch_vx = 10'(vx);
    launch_vy = 10'(vy);
    step();
    launch    = 1'b0;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    x_count = 10'(x);
    y_count = 10'(y);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    frame_tick = 1'b0;
    launch     = 1'b0;
    launch_vx  = '0;
    launch_vy  = '0;
    x_count    = '0;
    y_count    = '0;
    step();
    step();
    check("rst_busy", 32'(busy_mask), 0);
    check("rst_pix", 32'(ball_pix), 0);
    check("rst_score", 32'(score), 0);
    check("rst_land_valid", 32'(land_valid), 0);
    check("rst_drop", 32'(launch_drop), 0);
    rst = 1'b1;
    step();

    // Basic flight: x=55, y=413 after three ticks, then vy=7 applied.
    do_launch(5, 10);
    check("launch_busy_lat", 32'(busy_mask), 0);
    step();
    check("launch_busy", 32'(busy_mask), 4'b0001);
    do_tick(); do_tick(); do_tick();
    pix(55, 413);  check("fl_pix_tl", 32'(ball_pix), 1);
    check("fl_id_tl", 32'(ball_id), 0);
    pix(54, 413);  check("fl_pix_left", 32'(ball_pix), 0);
    check("fl_id_none", 32'(ball_id), 0);
    pix(55, 412);  check("fl_pix_above", 32'(ball_pix), 0);
    pix(62, 420);  check("fl_pix_br", 32'(ball_pix), 1);
    pix(63, 413);  check("fl_pix_right", 32'(ball_pix), 0);
    do_tick();
    pix(60, 406);  check("fl_pix_t4", 32'(ball_pix), 1);
    pix(60, 405);  check("fl_pix_t4_above", 32'(ball_pix), 0);

    // Fill all channels, then one more launch is dropped.
    do_launch(1, 1); do_launch(1, 1); do_launch(1, 1);
    check("fill_no_drop", 32'(launch_drop), 0);
    step();
    check("fill_busy", 32'(busy_mask), 4'b1111);
    do_launch(2, 2);
    check("drop_pulse", 32'(launch_drop), 1);
    step();
    check("drop_end", 32'(launch_drop), 0);
    check("drop_busy", 32'(busy_mask), 4'b1111);
    pix(60, 406);  check("drop_ball0_kept", 32'(ball_pix), 1);

    // vy=0: no contact on first tick.
    do_reset();
    do_launch(0, 0);
    do_tick();
    step();
    check("vy0_no_land", 32'(land_valid), 0);
    pix(40, 440);  check("vy0_pix", 32'(ball_pix), 1);

    // vy=-3: lands on first tick, clamped to y=442.
    do_reset();
    do_launch(0, -3);
    do_tick();
    check("land_lat", 32'(land_valid), 0);
    step();
    check("land_valid", 32'(land_valid), 1);
    check("land_id", 32'(land_id), 0);
    check("land_x", 32'(land_x), 40);
    check("land_hit", 32'(land_hit), 0);
    check("land_score", 32'(score), 0);
    step();
    check("land_one_shot", 32'(land_valid), 0);
    check("land_busy", 32'(busy_mask), 4'b0001);
    pix(40, 442);  check("land_clamp", 32'(ball_pix), 1);
    pix(40, 441);  check("land_clamp_above", 32'(ball_pix), 0);

    // Two landings in one frame: hit at x=470, miss at x=100.
    do_reset();
    do_launch(430, -3);
    do_launch(60, -3);
    do_tick();
    step();
    check("dual_v0", 32'(land_valid), 1);
    check("dual_id0", 32'(land_id), 0);
    check("dual_x0", 32'(land_x), 470);
    check("dual_hit0", 32'(land_hit), 1);
    check("dual_score0", 32'(score), 1);
    step();
    check("dual_v1", 32'(land_valid), 1);
    check("dual_id1", 32'(land_id), 1);
    check("dual_x1", 32'(land_x), 100);
    check("dual_hit1", 32'(land_hit), 0);
    check("dual_score1", 32'(score), 1);
    step();
    check("dual_done", 32'(land_valid), 0);

    // Left exit while also touching ground: exit wins, no event.
    do_reset();
    do_launch(-50, -3);
    step();
    do_tick();
    check("off_busy_lat", 32'(busy_mask), 4'b0001);
    step();
    check("off_busy", 32'(busy_mask), 0);
    check("off_no_evt0", 32'(land_valid), 0);
    step();
    check("off_no_evt1", 32'(land_valid), 0);

    // Right edge: x'=640 leaves, x'=638 stays.
    do_reset();
    do_launch(300, 5);
    do_launch(299, 5);
    do_tick(); do_tick();
    step();
    check("right_busy", 32'(busy_mask), 4'b0010);
    pix(638, 431); check("right_pix", 32'(ball_pix), 1);
    check("right_id", 32'(ball_id), 1);

    // Launch coinciding with a frame tick is not advanced.
    do_reset();
    launch     = 1'b1;
    frame_tick = 1'b1;
    launch_vx  = 10'd5;
    launch_vy  = 10'd10;
    step();
    launch     = 1'b0;
    frame_tick = 1'b0;
    pix(40, 440);  check("coinc_start", 32'(ball_pix), 1);
    pix(45, 430);  check("coinc_not_moved", 32'(ball_pix), 0);

    // Four-way landings repeated until the score saturates.
    do_reset();
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 4; c++) do_launch(430, -3);
      do_tick();
      for (int k = 0; k < 4; k++) begin
        step();
        if (r == 0) begin
          check("drain_valid", 32'(land_valid), 1);
          check("drain_id", 32'(land_id), 32'(k));
        end
      end
      step();
      if (r == 0) begin
        check("drain_done", 32'(land_valid), 0);
        check("drain_score", 32'(score), 4);
      end
      pix(470, 442);
      if (r == 0) check("prio_id", 32'(ball_id), 0);
      repeat (59) do_tick();
      step();
      if (r == 0) check("hold_59", 32'(busy_mask), 4'b1111);
      do_tick();
      step();
      if (r == 0) check("hold_60", 32'(busy_mask), 4'b0000);
      if (r == 62) check("score_252", 32'(score), 252);
    end
    check("score_sat", 32'(score), 255);

    // Asynchronous reset mid-flight clears outputs without a clock edge.
    do_launch(5, 10);
    do_tick();
    pix(45, 430);
    check("mid_pix", 32'(ball_pix), 1);
    check("mid_busy", 32'(busy_mask), 4'b0001);
    rst = 1'b0;
    #1;
    check("async_pix", 32'(ball_pix), 0);
    check("async_busy", 32'(busy_mask), 0);
    check("async_score", 32'(score), 0);
    check("async_valid", 32'(land_valid), 0);
    #3;
    rst = 1'b1;
    step();
    check("post_rst_busy", 32'(busy_mask), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
